jk_register_bank: RTL and testbench
===================================

# jk_register_bank

Parametrised, multi-bit successor to the single 74HC112 JK flip-flop. It holds WIDTH JK cells that share one clock and can act in four modes: a per-bit JK register, a synchronous modulo up counter, a down counter, or a parallel-load register. Per-bit synchronous set and clear follow the 74HC112 priority. The block sits in the same discrete-logic-equivalent library and replaces chained single-bit flip-flop instances in counter and register designs.

## Interface
- WIDTH, 4, number of JK cells (≥1)
- MODULUS, 2**WIDTH, counter modulus in up/down modes (2 ≤ MODULUS ≤ 2**WIDTH)
- Clk  input  1  rising-edge clock
- R_N  input  1  reset, synchronous, active-low; clears the whole bank
- S  input  WIDTH  per-bit synchronous set, active-high
- R  input  WIDTH  per-bit synchronous clear, active-high
- En  input  1  clock enable for mode operation; does not gate R_N, R or S
- Mode  input  2  00 JK, 01 count up, 10 count down, 11 parallel load
- J  input  WIDTH  per-bit J (JK mode only)
- K  input  WIDTH  per-bit K (JK mode only)
- D  input  WIDTH  load data (mode 11 only)
- Q  output  WIDTH  registered state
- Q_N  output  WIDTH  bitwise ~Q, combinational
- TC  output  1  terminal count, combinational

## Operation
- Priority at each rising Clk, from highest to lowest:
  1. R_N=0: Q←0.
  2. Per bit i, R[i]=1: Q[i]←0. Clear wins over S[i].
  3. Per bit i, S[i]=1: Q[i]←1.
  4. En=0: hold.
  5. Mode action.
- The mode action applies only to bits not claimed by R or S.
  - In counter and load modes, bits claimed by R or S override the corresponding bits of the computed next value.
- JK (00), per bit:
  - JK=00: hold.
  - JK=01: clear to 0.
  - JK=10: set to 1.
  - JK=11: toggle.
- Up (01):
  - Q≥MODULUS−1 → Q←0.
  - Otherwise Q←Q+1.
- Down (10):
  - Q=0 or Q≥MODULUS → Q←MODULUS−1.
  - Otherwise Q←Q−1.
- Load (11): Q←D, including values ≥MODULUS; no range check.
- Arithmetic is unsigned and WIDTH bits wide. The +1/−1 compare is done at WIDTH+1 bits so MODULUS=2**WIDTH is legal.
- TC=1 iff R_N=1 and En=1 and either:
  - Mode=01 and Q=MODULUS−1, or
  - Mode=10 and Q=0.
- Otherwise TC=0. TC is 0 in modes 00 and 11.

## Timing
- Every change to Q occurs at a rising Clk edge. Latency from input to Q is one cycle.
- Q_N and TC follow Q, Mode and En combinationally within the same cycle.
- Reset values while R_N=0: Q=0, Q_N=all ones, TC=0, regardless of the other inputs.
- Reset mid-count: the count is abandoned. On the first edge after R_N returns high, Q advances from 0.
- A Mode change takes effect on the next edge; there is no pipeline and no state is carried between modes.
- TC is asserted during the cycle whose closing edge produces the wrap. Cascaded banks use the upper bank's En = lower bank's TC.

## Structure
- Package jk_bank_pkg holds:
  - Mode constants MODE_JK, MODE_UP, MODE_DN, MODE_LD.
  - A 2-bit mode typedef.
- One sub-module, jk_cell: a single bit with inputs R_N, R, S, En, J, K, Q.
  - It implements priority levels 1–4 and JK behaviour.
- The bank top computes counter and load next-state per bit.
  - It drives each cell as follows: load → J=next, K=~next; cells not being changed → J=K=0.

## Test plan
- Reset: R_N=0 for 2 cycles with S=all ones and Mode=01 → Q=0, Q_N=F, TC=0 (WIDTH=4).
- JK: Q=0101, J=0011, K=0110 → Q=0011. Then J=K=1111 → Q=1100.
- Up count with MODULUS=10, En=1 from Q=0:
  - After 9 edges, Q=9 and TC=1.
  - The next edge gives Q=0 and TC=0.
  - With En=0, Q holds.
- Down and load, MODULUS=10:
  - Load D=12, then Mode=10 → Q=9.
  - From Q=0 in down mode, TC=1 and the next edge gives Q=9.
- Priority: Mode=11, D=1111, R=0001, S=0011 → Q=1110.
  - R_N=0 in the same cycle → Q=0.
- Cascade: two WIDTH=4 banks with the upper En = lower TC, counting up from 0.
  - After 255 edges, the pair reads FF.
  - After the 256th edge, the pair reads 00.

Source files
------------

// File: rtl/jk_bank_pkg.sv
// Shared mode encoding for the JK register bank.
package jk_bank_pkg;

   typedef enum logic [1:0] {
      MODE_JK = 2'b00,
      MODE_UP = 2'b01,
      MODE_DN = 2'b10,
      MODE_LD = 2'b11
   } mode_t;

endpackage : jk_bank_pkg

// File: rtl/jk_cell.sv
// Single JK storage cell: reset, per-bit clear/set, clock enable, JK action.
module jk_cell (
   input  logic Clk,
   input  logic R_N,
   input  logic R,
   input  logic S,
   input  logic En,
   input  logic J,
   input  logic K,
   output logic Q
);

   logic r_q;

   // Priority: bank reset, clear, set, enable gate, then JK behaviour.
   always_ff @(posedge Clk) begin
      if (!R_N) begin
         r_q <= 1'b0;
      end else if (R) begin
         r_q <= 1'b0;
      end else if (S) begin
         r_q <= 1'b1;
      end else if (En) begin
         case ({J, K})
            2'b00:   r_q <= r_q;
            2'b01:   r_q <= 1'b0;
            2'b10:   r_q <= 1'b1;
            default: r_q <= ~r_q;
         endcase
      end
   end

   assign Q = r_q;

endmodule : jk_cell

// File: rtl/jk_register_bank.sv
// Bank of WIDTH JK cells acting as JK register, modulo up/down counter or loader.
module jk_register_bank
   import jk_bank_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 2 ** WIDTH
) (
   input  logic             Clk,
   input  logic             R_N,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] R,
   input  logic             En,
   input  logic [1:0]       Mode,
   input  logic [WIDTH-1:0] J,
   input  logic [WIDTH-1:0] K,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_N,
   output logic             TC
);

   // Compares are WIDTH+1 bits wide so MODULUS = 2**WIDTH is representable.
   localparam logic [WIDTH:0]   C_MOD   = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH:0]   C_TOP   = C_MOD - 1'b1;
   localparam logic [WIDTH-1:0] C_TOP_Q = C_TOP[WIDTH-1:0];

   mode_t            w_mode;
   logic [WIDTH-1:0] w_q;
   logic [WIDTH:0]   w_q_ext;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;

   assign w_mode  = mode_t'(Mode);
   assign w_q_ext = {1'b0, w_q};

   // Next bank value for the counter and load modes.
   always_comb begin
      w_next = w_q;
      case (w_mode)
         MODE_UP: begin
            if (w_q_ext >= C_TOP) w_next = '0;
            else                  w_next = w_q + 1'b1;
         end
         MODE_DN: begin
            if (w_q == '0 || w_q_ext >= C_MOD) w_next = C_TOP_Q;
            else                               w_next = w_q - 1'b1;
         end
         MODE_LD: w_next = D;
         default: w_next = w_q;
      endcase
   end

   // Counter/load modes force each cell via J=next, K=~next; R/S win inside the cell.
   always_comb begin
      w_j = '0;
      w_k = '0;
      if (w_mode == MODE_JK) begin
         w_j = J;
         w_k = K;
      end else begin
         w_j = w_next;
         w_k = ~w_next;
      end
   end

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_cell
         jk_cell u_cell (
            .Clk (Clk),
            .R_N (R_N),
            .R   (R[g]),
            .S   (S[g]),
            .En  (En),
            .J   (w_j[g]),
            .K   (w_k[g]),
            .Q   (w_q[g])
         );
      end
   endgenerate

   assign Q   = w_q;
   assign Q_N = ~w_q;
   assign TC  = R_N && En &&
                (((w_mode == MODE_UP) && (w_q_ext == C_TOP)) ||
                 ((w_mode == MODE_DN) && (w_q == '0)));

endmodule : jk_register_bank

// File: tb/tb_jk_register_bank.sv
// Directed bench for jk_register_bank: a MODULUS=10 bank plus a cascaded 8-bit pair.
module tb_jk_register_bank;

   logic       Clk;
   logic       R_N;
   logic [3:0] S, R, J, K, D;
   logic       En;
   logic [1:0] Mode;
   logic [3:0] Q, Q_N;
   logic       TC;

   logic       c_rn;
   logic [3:0] lo_q, lo_qn, hi_q, hi_qn;
   logic       lo_tc, hi_tc;

   int n_vec = 0;
   int n_err = 0;

   jk_register_bank #(.WIDTH(4), .MODULUS(10)) u_dut (
      .Clk (Clk), .R_N (R_N), .S (S), .R (R), .En (En), .Mode (Mode),
      .J (J), .K (K), .D (D), .Q (Q), .Q_N (Q_N), .TC (TC)
   );

   jk_register_bank #(.WIDTH(4)) u_lo (
      .Clk (Clk), .R_N (c_rn), .S (4'h0), .R (4'h0), .En (1'b1), .Mode (2'b01),
      .J (4'h0), .K (4'h0), .D (4'h0), .Q (lo_q), .Q_N (lo_qn), .TC (lo_tc)
   );

   jk_register_bank #(.WIDTH(4)) u_hi (
      .Clk (Clk), .R_N (c_rn), .S (4'h0), .R (4'h0), .En (lo_tc), .Mode (2'b01),
      .J (4'h0), .K (4'h0), .D (4'h0), .Q (hi_q), .Q_N (hi_qn), .TC (hi_tc)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      R_N = 1'b0; S = 4'hF; R = 4'h0; En = 1'b1; Mode = 2'b01;
      J = 4'h0; K = 4'h0; D = 4'h0;
      c_rn = 1'b0;

      // Reset held for two edges with S all ones and up mode
      step(); step();
      check("rst_q",   {4'h0, Q},   8'h00);
      check("rst_qn",  {4'h0, Q_N}, 8'h0F);
      check("rst_tc",  {7'h0, TC},  8'h00);

      // JK mode from Q=0101
      R_N = 1'b1; S = 4'h0; Mode = 2'b11; D = 4'h5;
      step();
      check("ld_5",    {4'h0, Q},   8'h05);
      Mode = 2'b00; J = 4'h3; K = 4'h6;
      #1 check("jk_tc",   {7'h0, TC},  8'h00);
      step();
      check("jk_mix",  {4'h0, Q},   8'h03);
      J = 4'hF; K = 4'hF;
      step();
      check("jk_tgl",  {4'h0, Q},   8'h0C);
      check("jk_qn",   {4'h0, Q_N}, 8'h03);

      // Up count modulo 10
      J = 4'h0; K = 4'h0; Mode = 2'b11; D = 4'h0;
      step();
      Mode = 2'b01;
      #1 check("up_tc0",  {7'h0, TC},  8'h00);
      repeat (9) step();
      check("up_9",    {4'h0, Q},   8'h09);
      check("up_tc9",  {7'h0, TC},  8'h01);
      En = 1'b0;
      #1 check("up_tcen", {7'h0, TC},  8'h00);
      En = 1'b1;
      step();
      check("up_wrap", {4'h0, Q},   8'h00);
      check("up_tcw",  {7'h0, TC},  8'h00);
      step();
      En = 1'b0;
      step(); step();
      check("up_hold", {4'h0, Q},   8'h01);
      En = 1'b1;

      // Up count from out-of-range value wraps to 0
      Mode = 2'b11; D = 4'hC;
      step();
      Mode = 2'b01;
      step();
      check("up_oor",  {4'h0, Q},   8'h00);

      // Load beyond modulus, then down count
      Mode = 2'b11; D = 4'hC;
      step();
      check("ld_12",   {4'h0, Q},   8'h0C);
      check("ld_tc",   {7'h0, TC},  8'h00);
      Mode = 2'b10;
      step();
      check("dn_oor",  {4'h0, Q},   8'h09);
      step();
      check("dn_8",    {4'h0, Q},   8'h08);
      Mode = 2'b11; D = 4'h0;
      step();
      Mode = 2'b10;
      #1 check("dn_tc0",  {7'h0, TC},  8'h01);
      step();
      check("dn_wrap", {4'h0, Q},   8'h09);
      check("dn_tc9",  {7'h0, TC},  8'h00);

      // Per-bit clear/set priority over load, then reset over everything
      Mode = 2'b11; D = 4'hF; R = 4'h1; S = 4'h3;
      step();
      check("prio",    {4'h0, Q},   8'h0E);
      check("prio_qn", {4'h0, Q_N}, 8'h01);
      R_N = 1'b0;
      #1 check("rst_tc2", {7'h0, TC},  8'h00);
      step();
      check("rst_mid", {4'h0, Q},   8'h00);

      // Reset mid-count: counting restarts from 0
      R = 4'h0; S = 4'h0; Mode = 2'b01; R_N = 1'b1;
      step();
      check("rst_adv", {4'h0, Q},   8'h01);

      // Cascade: upper En driven by lower TC
      c_rn = 1'b1;
      repeat (16) step();
      check("cas_16",  {hi_q, lo_q}, 8'h10);
      repeat (239) step();
      check("cas_255", {hi_q, lo_q}, 8'hFF);
      check("cas_tc",  {6'h0, hi_tc, lo_tc}, 8'h03);
      step();
      check("cas_256", {hi_q, lo_q}, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_jk_register_bank
